// File: rtl/data_bus_ctrl_pkg.sv
// Shared definitions for the data-side bus controller: FSM encodings,
// the read value returned on a bus error, and the index-width helper.
package data_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // A single slave still needs one index bit so the range check stays meaningful.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave decode: index from the top address bits, one-hot
// request vector and in-range flag. Shared with the instruction-side controller.
module bus_addr_decode
  import data_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] req_onehot,
  output logic                  in_range
);

  logic unused_low_bits;
  assign unused_low_bits = ^addr[ADDR_W-IDX_W-1:0];

  always_comb begin
    idx        = addr[ADDR_W-1 -: IDX_W];
    in_range   = (32'(idx) < NUM_SLAVES);
    req_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (32'(idx) == k);
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes the slave, runs a registered req/ack
// handshake and stalls the CPU. Optional wait timeout via `BUS_TIMEOUT_EN.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_ce_i,
  input  logic                         cpu_we_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W/8-1:0]          cpu_sel_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  output logic                         cpu_stall_o,
  output logic                         cpu_err_o,
  output logic [NUM_SLAVES-1:0]        s_req_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int SEL_W = DATA_W / 8;

  bus_state_e state_q, state_d;

  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [SEL_W-1:0]      sel_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NUM_SLAVES-1:0] req_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  dec_in_range;
  logic                  unused_idx;

  logic                  ack_hit;
  logic                  timeout_hit;
  logic [DATA_W-1:0]     sel_rdata;

  bus_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr       (cpu_addr_i),
    .idx        (dec_idx),
    .req_onehot (dec_onehot),
    .in_range   (dec_in_range)
  );

  assign unused_idx = ^dec_idx;

  // The latched one-hot vector selects both the ack and the read lane,
  // so acks from other slaves never reach the FSM.
  assign ack_hit = |(s_ack_i & req_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (req_q[k]) sel_rdata = sel_rdata | s_rdata_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              wait_cnt_q <= '0;
    else if (state_q == ST_REQ && !ack_hit) wait_cnt_q <= wait_cnt_q + 8'd1;
    else                                   wait_cnt_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Stall is raised combinationally in the request cycle so the CPU never
  // advances past an access that has not been accepted yet.
  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    cpu_err_o   = 1'b0;
    s_req_o     = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_ce_i) begin
          cpu_stall_o = 1'b1;
          state_d     = dec_in_range ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        cpu_stall_o = 1'b1;
        s_req_o     = req_q;
        if (ack_hit || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        cpu_err_o = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack is tested before timeout so a simultaneous ack completes cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cpu_ce_i) begin
        we_q    <= cpu_we_i;
        addr_q  <= cpu_addr_i;
        sel_q   <= cpu_sel_i;
        wdata_q <= cpu_wdata_i;
        req_q   <= dec_onehot;
        err_q   <= !dec_in_range;
        if (!dec_in_range && !cpu_we_i) rdata_q <= DATA_W'(ERR_RDATA);
      end
      if (state_q == ST_REQ) begin
        if (ack_hit) begin
          if (!we_q) rdata_q <= sel_rdata;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
          if (!we_q) rdata_q <= DATA_W'(ERR_RDATA);
        end
      end
    end
  end

  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_sel_o     = sel_q;
  assign s_wdata_o   = wdata_q;
  assign cpu_rdata_o = rdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: a 4-slave instance (TIMEOUT=8) and a
// 3-slave instance for decode errors; behaviour follows BUS_TIMEOUT_EN.
module tb_data_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_ce, ce3, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_sel;

  logic [31:0]  rdata4, s_addr4, s_wdata4;
  logic         stall4, err4, s_we4;
  logic [3:0]   s_req4, s_sel4, s_ack4;
  logic [127:0] s_rdata4;

  logic [31:0]  rdata3, s_addr3, s_wdata3;
  logic         stall3, err3, s_we3;
  logic [2:0]   s_req3, s_ack3;
  logic [3:0]   s_sel3;
  logic [95:0]  s_rdata3;

  int checks = 0;
  int fails  = 0;

  data_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(8)) dut4 (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_sel_i(cpu_sel), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(rdata4), .cpu_stall_o(stall4), .cpu_err_o(err4),
    .s_req_o(s_req4), .s_we_o(s_we4), .s_addr_o(s_addr4),
    .s_sel_o(s_sel4), .s_wdata_o(s_wdata4),
    .s_rdata_i(s_rdata4), .s_ack_i(s_ack4)
  );

  data_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(255)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_ce_i(ce3), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_sel_i(cpu_sel), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(rdata3), .cpu_stall_o(stall3), .cpu_err_o(err3),
    .s_req_o(s_req3), .s_we_o(s_we3), .s_addr_o(s_addr3),
    .s_sel_o(s_sel3), .s_wdata_o(s_wdata3),
    .s_rdata_i(s_rdata3), .s_ack_i(s_ack3)
  );

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({stall4, err4, s_we4} !== 3'b000) begin fails++; $display("[TB] FAIL reset_ctl4: got %b expected 000", {stall4, err4, s_we4}); end
    checks++; if (s_req4 !== 4'h0) begin fails++; $display("[TB] FAIL reset_req4: got %h expected 0", s_req4); end
    checks++; if ({rdata4, s_addr4, s_wdata4, s_sel4} !== 100'h0) begin fails++; $display("[TB] FAIL reset_data4: got %h expected 0", {rdata4, s_addr4, s_wdata4, s_sel4}); end
    checks++; if ({stall3, err3, s_req3, rdata3} !== 37'h0) begin fails++; $display("[TB] FAIL reset_dut3: got %h expected 0", {stall3, err3, s_req3, rdata3}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    int stall_cycles = 0;
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0010; cpu_sel = 4'hF;
    s_rdata4[63:32] = 32'hCAFE_0001;
    sample();
    if (stall4) stall_cycles++;
    checks++; if (stall4 !== 1'b1) begin fails++; $display("[TB] FAIL rd_idle_stall: got %b expected 1", stall4); end
    checks++; if (s_req4 !== 4'h0) begin fails++; $display("[TB] FAIL rd_idle_req: got %h expected 0", s_req4); end
    drive_edge();
    s_ack4 = 4'b0010;
    sample();
    if (stall4) stall_cycles++;
    checks++; if (s_req4 !== 4'b0010) begin fails++; $display("[TB] FAIL rd_req: got %b expected 0010", s_req4); end
    checks++; if ({s_we4, s_addr4} !== {1'b0, 32'h4000_0010}) begin fails++; $display("[TB] FAIL rd_addr: got %h expected 040000010", {s_we4, s_addr4}); end
    drive_edge();
    s_ack4 = 4'h0; cpu_ce = 1'b0;
    sample();
    checks++; if (stall4 !== 1'b0) begin fails++; $display("[TB] FAIL rd_done_stall: got %b expected 0", stall4); end
    checks++; if (rdata4 !== 32'hCAFE_0001) begin fails++; $display("[TB] FAIL rd_data: got %h expected cafe0001", rdata4); end
    checks++; if (err4 !== 1'b0) begin fails++; $display("[TB] FAIL rd_err: got %b expected 0", err4); end
    checks++; if (stall_cycles != 2) begin fails++; $display("[TB] FAIL rd_stall_cycles: got %0d expected 2", stall_cycles); end
  endtask

  task automatic test_write_wait3();
    int stall_cycles = 0;
    int req_cycles = 0;
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_sel = 4'b0011;
    cpu_wdata = 32'h1234_5678; s_rdata4[31:0] = 32'hDEAD_0000;
    sample();
    if (stall4) stall_cycles++;
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      s_ack4 = (i == 3) ? 4'b0001 : 4'b0100;
      sample();
      if (stall4) stall_cycles++;
      if (s_req4 == 4'b0001) req_cycles++;
      checks++; if ({s_we4, s_sel4, s_wdata4} !== {1'b1, 4'b0011, 32'h1234_5678}) begin fails++; $display("[TB] FAIL wr_outputs%0d: got %h expected 131234 5678", i, {s_we4, s_sel4, s_wdata4}); end
    end
    drive_edge();
    s_ack4 = 4'h0; cpu_ce = 1'b0;
    sample();
    checks++; if ({stall4, err4} !== 2'b00) begin fails++; $display("[TB] FAIL wr_done: got %b expected 00", {stall4, err4}); end
    checks++; if (rdata4 !== 32'hCAFE_0001) begin fails++; $display("[TB] FAIL wr_rdata_kept: got %h expected cafe0001", rdata4); end
    checks++; if (stall_cycles != 5) begin fails++; $display("[TB] FAIL wr_stall_cycles: got %0d expected 5", stall_cycles); end
    checks++; if (req_cycles != 4) begin fails++; $display("[TB] FAIL wr_req_cycles: got %0d expected 4", req_cycles); end
  endtask

  task automatic test_decode_error();
    drive_edge();
    ce3 = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0000;
    s_rdata3[95:64] = 32'h55AA_55AA;
    sample();
    drive_edge();
    s_ack3 = 3'b100;
    sample();
    checks++; if (s_req3 !== 3'b100) begin fails++; $display("[TB] FAIL dec_good_req: got %b expected 100", s_req3); end
    drive_edge();
    s_ack3 = 3'b000; cpu_addr = 32'hC000_0000;
    sample();
    checks++; if (rdata3 !== 32'h55AA_55AA) begin fails++; $display("[TB] FAIL dec_good_data: got %h expected 55aa55aa", rdata3); end
    drive_edge();
    sample();
    checks++; if ({stall3, s_req3} !== 4'b1000) begin fails++; $display("[TB] FAIL dec_idle: got %b expected 1000", {stall3, s_req3}); end
    drive_edge();
    ce3 = 1'b0;
    sample();
    checks++; if ({stall3, err3, s_req3} !== 5'b01000) begin fails++; $display("[TB] FAIL dec_done: got %b expected 01000", {stall3, err3, s_req3}); end
    checks++; if (rdata3 !== 32'h0) begin fails++; $display("[TB] FAIL dec_rdata: got %h expected 0", rdata3); end
    drive_edge();
    sample();
    checks++; if (err3 !== 1'b0) begin fails++; $display("[TB] FAIL dec_err_pulse: got %b expected 0", err3); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0004; s_ack4 = 4'h0;
    sample();
`ifdef BUS_TIMEOUT_EN
    begin
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        drive_edge();
        sample();
        if (stall4) begin
          if (s_req4 == 4'b1000) req_cycles++;
        end else begin
          done = 1'b1;
        end
      end
      checks++; if (!done) begin fails++; $display("[TB] FAIL to_bound: got stall after 40 cycles expected done"); end
      checks++; if (req_cycles != 8) begin fails++; $display("[TB] FAIL to_req_cycles: got %0d expected 8", req_cycles); end
      checks++; if ({err4, s_req4} !== 5'b10000) begin fails++; $display("[TB] FAIL to_err: got %b expected 10000", {err4, s_req4}); end
      checks++; if (rdata4 !== 32'h0) begin fails++; $display("[TB] FAIL to_rdata: got %h expected 0", rdata4); end
      drive_edge();
      cpu_ce = 1'b0;
      sample();
    end
`else
    for (int i = 0; i < 1000; i++) begin
      drive_edge();
      sample();
      if (stall4 && s_req4 == 4'b1000) req_cycles++;
    end
    checks++; if (req_cycles != 1000) begin fails++; $display("[TB] FAIL noto_stall_cycles: got %0d expected 1000", req_cycles); end
    checks++; if (err4 !== 1'b0) begin fails++; $display("[TB] FAIL noto_err: got %b expected 0", err4); end
`endif
  endtask

  task automatic test_async_reset();
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4000_0008; cpu_sel = 4'b1100;
    cpu_wdata = 32'hA5A5_0F0F; s_ack4 = 4'h0;
    sample();
    drive_edge();
    sample();
`ifdef BUS_TIMEOUT_EN
    checks++; if ({stall4, s_req4} !== 5'b10010) begin fails++; $display("[TB] FAIL rst_pre: got %b expected 10010", {stall4, s_req4}); end
`else
    checks++; if ({stall4, s_req4} !== 5'b11000) begin fails++; $display("[TB] FAIL rst_pre: got %b expected 11000", {stall4, s_req4}); end
`endif
    #2;
    cpu_ce = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if ({stall4, err4, s_we4, s_req4} !== 7'h0) begin fails++; $display("[TB] FAIL rst_ctl: got %b expected 0", {stall4, err4, s_we4, s_req4}); end
    checks++; if ({s_addr4, s_sel4, s_wdata4, rdata4} !== 100'h0) begin fails++; $display("[TB] FAIL rst_data: got %h expected 0", {s_addr4, s_sel4, s_wdata4, rdata4}); end
    @(negedge clk);
    rst = 1'b1;
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0010; s_rdata4[63:32] = 32'h1357_9BDF;
    sample();
    checks++; if (stall4 !== 1'b1) begin fails++; $display("[TB] FAIL rst_after_stall: got %b expected 1", stall4); end
    drive_edge();
    s_ack4 = 4'b0010;
    sample();
    checks++; if (s_req4 !== 4'b0010) begin fails++; $display("[TB] FAIL rst_after_req: got %b expected 0010", s_req4); end
    drive_edge();
    s_ack4 = 4'h0; cpu_ce = 1'b0;
    sample();
    checks++; if ({stall4, err4, rdata4} !== {2'b00, 32'h1357_9BDF}) begin fails++; $display("[TB] FAIL rst_after_data: got %h expected 013579bdf", {stall4, err4, rdata4}); end
  endtask

  task automatic test_back_to_back();
    drive_edge();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0000;
    s_rdata4[95:64] = 32'h2222_0002; s_rdata4[127:96] = 32'h3333_0003;
    sample();
    drive_edge();
    s_ack4 = 4'b0100;
    sample();
    checks++; if (s_req4 !== 4'b0100) begin fails++; $display("[TB] FAIL b2b_req2: got %b expected 0100", s_req4); end
    drive_edge();
    s_ack4 = 4'h0; cpu_addr = 32'hC000_0000;
    sample();
    checks++; if ({stall4, rdata4} !== {1'b0, 32'h2222_0002}) begin fails++; $display("[TB] FAIL b2b_done1: got %h expected 022220002", {stall4, rdata4}); end
    drive_edge();
    sample();
    checks++; if ({stall4, s_req4} !== 5'b10000) begin fails++; $display("[TB] FAIL b2b_idle2: got %b expected 10000", {stall4, s_req4}); end
    drive_edge();
    s_ack4 = 4'b1000;
    sample();
    checks++; if (s_req4 !== 4'b1000) begin fails++; $display("[TB] FAIL b2b_req3: got %b expected 1000", s_req4); end
    drive_edge();
    s_ack4 = 4'h0; cpu_ce = 1'b0;
    sample();
    checks++; if ({stall4, err4, rdata4} !== {2'b00, 32'h3333_0003}) begin fails++; $display("[TB] FAIL b2b_done2: got %h expected 033330003", {stall4, err4, rdata4}); end
  endtask

  initial begin
    rst = 1'b0; cpu_ce = 1'b0; ce3 = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    s_rdata4 = '0; s_ack4 = '0; s_rdata3 = '0; s_ack3 = '0;
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_decode_error();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Parametrised data-side bus controller sitting between the CPU core's RAM port and a set of memory-mapped slave channels (data RAM, peripherals) inside the SOPC top. It decodes the slave index from the upper address bits, drives a registered request/acknowledge handshake toward the selected slave, and stalls the CPU until the transfer completes or times out. It replaces the direct zero-wait CPU-to-RAM wiring with multi-slave, variable-latency access.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte selects are DATA_W/8 wide
- NUM_SLAVES, 4, slave channel count (1..16)
- TIMEOUT, 255, max wait cycles per transfer before error (8-bit counter)
- IDX_W, $clog2(NUM_SLAVES) (min 1), derived localparam
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_ce_i  in  1  CPU access request
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_W  byte address
- cpu_sel_i  in  DATA_W/8  byte enables
- cpu_wdata_i  in  DATA_W  write data
- cpu_rdata_o  out  DATA_W  read data, valid in DONE
- cpu_stall_o  out  1  hold CPU pipeline
- cpu_err_o  out  1  one-cycle bus error pulse in DONE
- s_req_o  out  NUM_SLAVES  one-hot request, held until ack
- s_we_o  out  1  shared registered write enable
- s_addr_o  out  ADDR_W  shared registered address
- s_sel_o  out  DATA_W/8  shared registered byte enables
- s_wdata_o  out  DATA_W  shared registered write data
- s_rdata_i  in  NUM_SLAVES*DATA_W  per-slave read data, slave k at bits [k*DATA_W +: DATA_W]
- s_ack_i  in  NUM_SLAVES  per-slave acknowledge

## Operation
- Slave index = cpu_addr_i[ADDR_W-1 -: IDX_W].
- FSM states: IDLE, REQ, DONE.
- IDLE: cpu_ce_i=1 -> cpu_stall_o=1 combinationally same cycle; latch we/addr/sel/wdata/index. Index < NUM_SLAVES -> REQ. Index >= NUM_SLAVES -> DONE with error.
- REQ: s_req_o[idx]=1, other bits 0. On s_ack_i[idx]=1: capture s_rdata_i[idx] (reads only; writes leave cpu_rdata_o unchanged), -> DONE. Acks from non-selected slaves are ignored.
- DONE: cpu_stall_o=0, cpu_err_o as latched, s_req_o=0. Always -> IDLE. The CPU must drop or change cpu_ce_i in DONE. A cpu_ce_i still high in the following IDLE starts a new transfer.
- Error read returns cpu_rdata_o = 0.
- Reset (async, mid-transfer included): state IDLE; s_req_o=0, s_we_o=0, s_addr_o=0, s_sel_o=0, s_wdata_o=0, cpu_rdata_o=0, cpu_err_o=0, cpu_stall_o=0, wait counter 0. In-flight transfer is abandoned, with no ack replay.

## Timing
- Zero-wait slave (ack in first REQ cycle): stall high for 2 cycles (IDLE request cycle + REQ). Data is available in DONE, 2 cycles after ce.
- Each additional slave wait cycle adds 1 stall cycle.
- Decode error: 1 stall cycle, then DONE.
- Slave outputs are registered, stable for the whole REQ phase.
- Slave ack is sampled only in REQ. Ack in same edge as timeout expiry: ack wins, no error.

## Configuration
- BUS_TIMEOUT_EN defined: 8-bit wait counter clears on entering REQ and increments each REQ cycle without ack. Reaching TIMEOUT -> DONE with err=1, rdata 0, s_req_o dropped.
- Not defined: no counter. REQ waits indefinitely for ack. cpu_err_o is asserted only on decode error.

## Structure
- Shared package/defines: state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and error read value constant. They go with the existing global defines.
- Natural sub-module: bus_addr_decode, combinational index extraction, one-hot request vector and range check. Also used by future instruction-side controller.
- FSM, capture registers and timeout counter stay in data_bus_ctrl.

## Test plan
- Read, slave 1, ack in first REQ cycle, s_rdata_i[1]=32'hCAFE0001, addr 32'h4000_0010 (NUM_SLAVES=4) -> stall 2 cycles, cpu_rdata_o=32'hCAFE0001 in DONE, err=0.
- Write, slave 0, sel=4'b0011, wdata=32'h1234_5678, ack after 3 waits -> s_req_o=4'b0001 for 4 cycles, s_sel_o/s_wdata_o stable, stall 5 cycles.
- NUM_SLAVES=3, addr 32'hC000_0000 -> no s_req_o, err pulse in DONE, rdata 0, stall 1 cycle.
- BUS_TIMEOUT_EN, TIMEOUT=8, slave never acks -> err after 8 REQ cycles, s_req_o drops. Without macro -> stall persists for 1000 cycles.
- rst low during REQ -> all outputs 0 asynchronously. After release, the next access completes normally.
- Back-to-back reads slave 2 then 3 with ce held -> two complete transfers, one DONE cycle between them, correct data each.
